// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5 octal) hard-decision Viterbi decoder.
// The optional best-metric output is built only when VITERBI_METRIC_OUT_EN is defined.
package viterbi_pkg;

    localparam int N_SYM = 8;   // coded symbols per block
    localparam int MW    = 5;   // path-metric width, 2^MW > 2*N_SYM
    localparam int NS    = 4;   // trellis states
    localparam int CW    = $clog2(N_SYM);

    localparam logic [2:0]    G0      = 3'b111;
    localparam logic [2:0]    G1      = 3'b101;
    localparam logic [MW-1:0] MET_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACS   = 2'd1,
        TRACE = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    // Encoder output pair {g0,g1} for input u leaving state {s1,s2}.
    function automatic logic [1:0] enc_pair(input logic [1:0] st, input logic u);
        logic [2:0] shreg;
        shreg = {u, st};
        return {^(shreg & G0), ^(shreg & G1)};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Combinational add-compare-select over the 4-state trellis for one received symbol.
// State {u,s1} has predecessors {s1,0} and {s1,1}; ties keep the lower-index predecessor.
module viterbi_acs_unit
    import viterbi_pkg::*;
(
    input  logic [NS-1:0][MW-1:0] metric_in,
    input  logic [1:0]            sym,
    output logic [NS-1:0][MW-1:0] metric_out,
    output logic [NS-1:0]         dec
);

    logic [NS-1:0][MW-1:0] cand0;
    logic [NS-1:0][MW-1:0] cand1;

    // Predecessor metric plus Hamming branch metric, saturating at all ones.
    function automatic logic [MW-1:0] path_cand(input logic [MW-1:0] m,
                                                input logic [1:0]    ps,
                                                input logic          u,
                                                input logic [1:0]    rx);
        logic [1:0] diff;
        logic [MW:0] sum;
        diff = enc_pair(ps, u) ^ rx;
        sum  = {1'b0, m} + (MW+1)'(diff[0]) + (MW+1)'(diff[1]);
        if (sum > {1'b0, MET_MAX})
            return MET_MAX;
        else
            return sum[MW-1:0];
    endfunction

    // Evaluate both predecessors of every state and keep the survivor.
    always_comb begin
        cand0      = '0;
        cand1      = '0;
        metric_out = '0;
        dec        = '0;
        for (int s = 0; s < NS; s++) begin
            cand0[s]      = path_cand(metric_in[(s % 2) * 2],     2'((s % 2) * 2),     s >= 2, sym);
            cand1[s]      = path_cand(metric_in[(s % 2) * 2 + 1], 2'((s % 2) * 2 + 1), s >= 2, sym);
            dec[s]        = (cand1[s] < cand0[s]);
            metric_out[s] = dec[s] ? cand1[s] : cand0[s];
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Block Viterbi decoder: captures one 16-bit coded block, runs N_SYM ACS steps,
// then N_SYM traceback steps, and parks in DONE with a sticky done_flag until rst.
// Define VITERBI_METRIC_OUT_EN to add the best_metric output (minimum final metric).
// Handshake: en is a plain clock enable; en=0 freezes every register in every state.
module viterbi_decoder
    import viterbi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2*N_SYM-1:0]   data,
    output logic [N_SYM-1:0]     data_out,
    output logic                 done_flag
`ifdef VITERBI_METRIC_OUT_EN
    , output logic [MW-1:0]      best_metric
`endif
);

    localparam logic [CW-1:0] LAST = CW'(N_SYM - 1);

    fsm_state_t            state, next_state;
    logic [2*N_SYM-1:0]    data_reg;
    logic [NS-1:0][MW-1:0] metric;
    logic [NS-1:0][MW-1:0] acs_metric;
    logic [NS-1:0]         acs_dec;
    logic [NS-1:0]         dec_mem [N_SYM];
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         step_k;
    logic [1:0]            tb_state;
    logic [1:0]            cur_state;
    logic [1:0]            best_state;
    logic [MW-1:0]         best_val;

    // Symbol under decode is always the top pair; the register shifts left each ACS step.
    viterbi_acs_unit u_acs (
        .metric_in  (metric),
        .sym        (data_reg[2*N_SYM-1 -: 2]),
        .metric_out (acs_metric),
        .dec        (acs_dec)
    );

    // Lowest-metric state, lowest index on a tie.
    always_comb begin
        best_state = '0;
        best_val   = metric[0];
        for (int s = 1; s < NS; s++) begin
            if (metric[s] < best_val) begin
                best_val   = metric[s];
                best_state = 2'(s);
            end
        end
    end

    // Traceback walks steps N_SYM-1 down to 0; the first step starts at the best state.
    always_comb begin
        step_k    = LAST - cnt;
        cur_state = (cnt == '0) ? best_state : tb_state;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (en)
            state <= next_state;
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = ACS;
            ACS:     if (cnt == LAST) next_state = TRACE;
            TRACE:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        done_flag = (state == DONE);
    end

    // Datapath: capture, metric/survivor update, and traceback fill of data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            cnt      <= '0;
            tb_state <= '0;
            data_out <= '0;
            for (int s = 0; s < NS; s++)
                metric[s] <= (s == 0) ? '0 : MET_MAX;
            for (int i = 0; i < N_SYM; i++)
                dec_mem[i] <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    data_reg <= data;
                end
                ACS: begin
                    data_reg     <= data_reg << 2;
                    metric       <= acs_metric;
                    dec_mem[cnt] <= acs_dec;
                    cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                TRACE: begin
                    data_out[cnt] <= cur_state[1];
                    tb_state      <= {cur_state[0], dec_mem[step_k][cur_state]};
                    cnt           <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef VITERBI_METRIC_OUT_EN
    // Latch the final minimum metric on the first traceback step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            best_metric <= '0;
        else if (en && state == TRACE && cnt == '0)
            best_metric <= best_val;
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: table of blocks plus reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_viterbi_decoder;
    import viterbi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [7:0]  data_out;
    logic        done_flag;
`ifdef VITERBI_METRIC_OUT_EN
    logic [MW-1:0] best_metric;
`endif

    int checks   = 0;
    int failures = 0;

    // Clock/reset block
    always #5 clk = ~clk;

    viterbi_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data      (data),
        .data_out  (data_out),
        .done_flag (done_flag)
`ifdef VITERBI_METRIC_OUT_EN
        , .best_metric (best_metric)
`endif
    );

    typedef struct {
        logic [15:0]   data;
        logic [7:0]    exp_out;
        logic [MW-1:0] exp_metric;
        int            stall_at;
        int            stall_len;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives en per the stall window and returns the edge on which done_flag first appears
    // (0 if it never appears within the budget).
    task automatic run_block(input logic [15:0] d, input int stall_at, input int stall_len,
                             output int lat);
        @(negedge clk);
        data = d;
        lat  = 0;
        for (int e = 1; e <= 100; e++) begin
            en = !(e > stall_at && e <= stall_at + stall_len);
            @(posedge clk);
            #1;
            if (done_flag) begin
                lat = e;
                break;
            end
        end
        en = 1'b1;
    endtask

    task automatic check_metric(input string name, input logic [MW-1:0] exp);
`ifdef VITERBI_METRIC_OUT_EN
        check(name, 32'(best_metric), 32'(exp));
`endif
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        en   = 1'b0;
        data = '0;

        vecs[0] = '{16'hE17E, 8'hB2, 5'd0, 0, 0, 17};  // error-free
        vecs[1] = '{16'hC17E, 8'hB2, 5'd1, 0, 0, 17};  // bit 13 flipped
        vecs[2] = '{16'h0000, 8'h00, 5'd0, 0, 0, 17};  // all zeros
        vecs[3] = '{16'hDAAA, 8'hFF, 5'd0, 0, 0, 17};  // all-ones message
        vecs[4] = '{16'hEC00, 8'h80, 5'd0, 0, 0, 17};  // single leading one
        vecs[5] = '{16'hE17E, 8'hB2, 5'd0, 4, 5, 22};  // en low for 5 edges mid-ACS

        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            #1;
            check($sformatf("v%0d_reset_done", i), 32'(done_flag), 32'd0);
            check($sformatf("v%0d_reset_out", i), 32'(data_out), 32'd0);
            check_metric($sformatf("v%0d_reset_metric", i), '0);
            run_block(vecs[i].data, vecs[i].stall_at, vecs[i].stall_len, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_out));
            check_metric($sformatf("v%0d_metric", i), vecs[i].exp_metric);
            // DONE must hold even while data moves
            @(negedge clk);
            data = ~vecs[i].data;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold_done", i), 32'(done_flag), 32'd1);
            check($sformatf("v%0d_hold_out", i), 32'(data_out), 32'(vecs[i].exp_out));
        end

        // Reset in the middle of traceback, then a fresh block
        do_reset();
        @(negedge clk);
        data = 16'hE17E;
        en   = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_trace_not_done", 32'(done_flag), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_done", 32'(done_flag), 32'd0);
        check("abort_out", 32'(data_out), 32'd0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        run_block(16'h0000, 0, 0, lat);
        check("after_abort_latency", 32'(lat), 32'd17);
        check("after_abort_out", 32'(data_out), 32'h00);
        check_metric("after_abort_metric", '0);

        // Back-to-back: new data arrives in DONE, then rst re-arms
        do_reset();
        run_block(16'hC17E, 0, 0, lat);
        check("b2b_first_out", 32'(data_out), 32'hB2);
        @(negedge clk);
        data = 16'hDAAA;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_ignore_data", 32'(data_out), 32'hB2);
        do_reset();
        run_block(16'hDAAA, 0, 0, lat);
        check("b2b_second_latency", 32'(lat), 32'd17);
        check("b2b_second_out", 32'(data_out), 32'hFF);
        check_metric("b2b_second_metric", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
